// File: rtl/game_flow_ctl.sv
// Game flow sequencer: walks IDLE -> LOAD -> PLAY -> WIN through the levels and
// ends in DONE, driving the hero reset pulse and the movement freeze.
module game_flow_ctl #(
  parameter int NUM_LEVELS = 4,
  parameter int RST_CYCLES = 16,
  parameter int WIN_FRAMES = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        vsync_in,
  input  logic        goal_hit,
  input  logic [23:0] score,
  input  logic [23:0] score_req,
  output logic [3:0]  level,
  output logic        hero_rst,
  output logic        freeze,
  output logic [2:0]  game_state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PLAY = 3'd2;
  localparam logic [2:0] ST_WIN  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);
  localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES - 1);
  localparam logic [7:0] WIN_LAST   = 8'(WIN_FRAMES - 1);

  logic [2:0] state_reg, state_next;
  logic [3:0] level_reg, level_next;
  logic [7:0] cycle_cnt_reg, cycle_cnt_next;
  logic [7:0] frame_cnt_reg, frame_cnt_next;
  logic       start_d_reg;
  logic       vsync_d_reg;
  logic       hero_rst_reg;
  logic       freeze_reg;

  logic start_edge;
  logic frame_tick;
  logic score_ok;

  assign start_edge = start & ~start_d_reg;
  assign frame_tick = vsync_in & ~vsync_d_reg;
  assign score_ok   = (score >= score_req);

  always_comb begin
    state_next     = state_reg;
    level_next     = level_reg;
    cycle_cnt_next = cycle_cnt_reg;
    frame_cnt_next = frame_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start_edge) begin
          state_next = ST_LOAD;
          level_next = 4'd0;
        end
      end
      ST_LOAD: begin
        if (cycle_cnt_reg == RST_LAST) begin
          state_next = ST_PLAY;
        end else begin
          cycle_cnt_next = cycle_cnt_reg + 8'd1;
        end
      end
      ST_PLAY: begin
        if (goal_hit && score_ok) begin
          state_next = ST_WIN;
        end
      end
      ST_WIN: begin
        if (frame_tick) begin
          if (frame_cnt_reg == WIN_LAST) begin
            if (level_reg == LAST_LEVEL) begin
              state_next = ST_DONE;
            end else begin
              state_next = ST_LOAD;
              level_next = level_reg + 4'd1;
            end
          end else begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end
        end
      end
      ST_DONE: begin
        if (start_edge) begin
          state_next = ST_LOAD;
          level_next = 4'd0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Every state starts its counting from zero.
    if (state_next != state_reg) begin
      cycle_cnt_next = 8'd0;
      frame_cnt_next = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      level_reg     <= 4'd0;
      cycle_cnt_reg <= 8'd0;
      frame_cnt_reg <= 8'd0;
      // Presetting the edge history blocks a button held through reset.
      start_d_reg   <= 1'b1;
      vsync_d_reg   <= 1'b1;
      hero_rst_reg  <= 1'b0;
      freeze_reg    <= 1'b1;
    end else begin
      state_reg     <= state_next;
      level_reg     <= level_next;
      cycle_cnt_reg <= cycle_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      start_d_reg   <= start;
      vsync_d_reg   <= vsync_in;
      hero_rst_reg  <= (state_next == ST_LOAD);
      freeze_reg    <= (state_next != ST_PLAY);
    end
  end

  assign game_state = state_reg;
  assign level      = level_reg;
  assign hero_rst   = hero_rst_reg;
  assign freeze     = freeze_reg;

endmodule

// File: doc/game_flow_ctl.md
GAME_FLOW_CTL -- requirements
Module: game_flow_ctl

Interface
REQ-001 The block SHALL expose parameter NUM_LEVELS, default 4, meaning the number of playable levels; the legal range SHALL be 1..16.
REQ-002 The block SHALL expose parameter RST_CYCLES, default 16, meaning the number of clocks hero_rst is held per level load; the legal range SHALL be 1..255.
REQ-003 The block SHALL expose parameter WIN_FRAMES, default 120, meaning the number of frames the level-complete pause lasts; the legal range SHALL be 1..255.
REQ-004 The ports SHALL be as follows (name, direction, width, meaning):
- clk, input, 1: pixel clock; the single clock of the block.
- rst, input, 1: reset; synchronous, active-high.
- start, input, 1: centre button, already synchronised; level signal.
- vsync_in, input, 1: VGA vsync; each rising edge is one frame tick.
- goal_hit, input, 1: hero overlaps the goal; level signal.
- score, input, 24: current score; unsigned.
- score_req, input, 24: score required to finish the level; unsigned.
- level, output, 4: current level index, 0..NUM_LEVELS-1.
- hero_rst, output, 1: reset pulse to hero and map control.
- freeze, output, 1: high means hero movement is inhibited.
- game_state, output, 3: encoded current state.

Function
REQ-005 All outputs SHALL be registered, and no output SHALL depend combinationally on any input.
REQ-006 The block SHALL implement exactly five states with these game_state encodings: IDLE=0, LOAD=1, PLAY=2, WIN=3, DONE=4. Codes 5..7 SHALL never appear and, if reached, SHALL go to IDLE on the next clock.
REQ-007 The block SHALL detect a start edge when start=1 in the current sample and start was 0 in the previous sample (start_d register).
REQ-008 The block SHALL detect a frame tick when vsync_in=1 in the current sample and vsync_in was 0 in the previous sample (vsync_d register).
REQ-009 The following transitions SHALL apply.
- IDLE, on a start edge: go to LOAD at the same clock edge; level is set to 0.
- LOAD: hero_rst=1 for exactly RST_CYCLES consecutive clocks, then go to PLAY.
- PLAY: if goal_hit=1 and score>=score_req (24-bit unsigned compare), go to WIN on the next clock edge.
- WIN: count frame ticks. On the WIN_FRAMES-th tick:
  - if level=NUM_LEVELS-1, go to DONE;
  - otherwise increment level by 1 and go to LOAD.
- DONE, on a start edge: set level to 0 and go to LOAD.
REQ-010 freeze SHALL be 0 only in PLAY and 1 in every other state.
REQ-011 hero_rst SHALL be 1 only while the state is LOAD.
REQ-012 level SHALL change only on entry to LOAD and SHALL never wrap beyond NUM_LEVELS-1.
REQ-013 A start edge in LOAD, PLAY or WIN SHALL be ignored.
REQ-014 goal_hit in any state other than PLAY SHALL be ignored.
REQ-015 In PLAY, if goal_hit=1 but score<score_req, the block SHALL stay in PLAY.
REQ-016 The frame counter and the cycle counter SHALL be cleared on every state entry, and a frame tick outside WIN SHALL not be counted.
REQ-017 If a start edge and a frame tick occur in the same clock, each SHALL be evaluated independently against the current state.
REQ-018 With NUM_LEVELS=1, the block SHALL go from WIN directly to DONE with level=0.

Reset
REQ-019 While rst=1 at a clock edge, the block SHALL set: state=IDLE, game_state=0, level=0, hero_rst=0, freeze=1, all counters=0, start_d=1, vsync_d=1.
REQ-020 Because start_d=1 after reset, a button held through reset SHALL NOT trigger a start; a fresh 0->1 transition SHALL be required.
REQ-021 A reset asserted in any state, including mid-LOAD or mid-WIN, SHALL override all transitions in that cycle.

Verification
REQ-022 Reset then start pulse: after rst, drive start 0 then 1. The response SHALL be: game_state=1, hero_rst=1 for 16 clocks, then game_state=2, freeze=0, level=0.
REQ-023 Goal without score: in PLAY, drive goal_hit=1, score=5, score_req=10. The block SHALL stay in PLAY. Then set score=10; game_state SHALL be 3 one clock later, with freeze=1.
REQ-024 Win pause: in WIN at level 0, apply 119 vsync rising edges; the block SHALL still be in WIN. After the 120th edge, level SHALL be 1 and game_state=1.
REQ-025 Final level: complete level 3 with NUM_LEVELS=4. The response SHALL be: game_state=4, level stays 3. Then a start edge SHALL give level=0, game_state=1.
REQ-026 Held button and mid-operation reset: hold start=1 through rst; the block SHALL remain in IDLE. Separately, assert rst in the 8th LOAD cycle; the next clock SHALL show game_state=0, hero_rst=0.
REQ-027 Ignored start: start edges during PLAY and WIN SHALL cause no state or level change.
